// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-ported word memory behind a valid/ready request channel and a
// valid/ready response channel. One transaction is in flight at a time:
//   IDLE   : req_ready=1, waits for a request handshake
//   ACCESS : performs the store, or registers the load data
//   RESP   : rsp_valid=1, holds the response until rsp_ready
// A request accepted at edge N can complete its response handshake at edge
// N+2. The next request can be accepted one edge after that handshake.
//
// Ports
//   clk        : sole clock; all state changes on posedge
//   rst        : synchronous, active-high; clears FSM, response, counter, memory
//   req_valid  : initiator presents a request
//   req_ready  : responder is idle and can accept a request
//   req_we     : 1 = store word, 0 = load word
//   req_addr   : word address (ADDRESS_WIDTH+1 bits, full decode)
//   req_wdata  : store data
//   rsp_valid  : response available
//   rsp_ready  : initiator consumes the response
//   rsp_rdata  : load data; 0 for a store response
//   rsp_we     : echo of the accepted req_we
//   txn_count  : completed response handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int WORD_SIZE     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDRESS_WIDTH:0] req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_we,
  output logic [15:0]            txn_count
);

  localparam int DEPTH = 2 ** (ADDRESS_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic                   lat_we;
  logic [ADDRESS_WIDTH:0] lat_addr;
  logic [WORD_SIZE-1:0]   lat_wdata;
  logic                   accept;
  logic                   rsp_fire;

  // Handshake qualifiers are derived purely from state, so request and
  // response inputs are ignored whenever the FSM is in the other phase.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment first guarantees state_next is written on
  // every path, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = ACCESS;
      ACCESS:                state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Request capture: inputs are only sampled on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // NOTE: the storage must read as zero after reset, so it is built from
  // resettable flops rather than a RAM macro; reset also wins over a store
  // pending in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (state == ACCESS && lat_we) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

  // Response payload is loaded once in ACCESS and then held through RESP,
  // which keeps it stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_we    <= lat_we;
      rsp_rdata <= lat_we ? '0 : mem[lat_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (rsp_fire) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule
